// File: rtl/im_sync.sv
// im_sync: clocked, word-addressed instruction memory with a request/response
// fetch port, configurable wait states, a program-load write port and
// alignment/range error reporting.
// Optional feature: define IM_BOOT_ROM_EN to overlay a five-word boot program
// on words 0..4 until each word is overwritten by a load.
// DEPTH_LOG2 must be at least 3 and below ADDR_WIDTH-2.
module im_sync #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_inst,
   output logic                  rsp_err,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  busy
);

   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [3:0]          WAIT_INIT  = 4'(WAIT_STATES);
   localparam logic [DEPTH_LOG2-1:0] BOOT_WORDS = DEPTH_LOG2'(5);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   rspValid_q, rspValid_d;
   logic [DATA_WIDTH-1:0]  rspInst_q, rspInst_d;
   logic                   rspErr_q, rspErr_d;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0]  decAddr;
   logic [DEPTH_LOG2-1:0]  fetchIdx;
   logic                   fetchErr;
   logic [DEPTH_LOG2-1:0]  loadIdx;
   logic                   loadWrite;
   logic                   loadHitsFetch;
   logic [DATA_WIDTH-1:0]  readWord;

   // With zero wait states the array is read on the acceptance edge itself,
   // so decode straight from the request address while idle; otherwise use
   // the latched fetch address.
   assign decAddr       = (state_q == IDLE) ? req_addr : addr_q;
   assign fetchIdx      = decAddr[DEPTH_LOG2+1:2];
   assign fetchErr      = (decAddr[1:0] != 2'b00) || ((decAddr >> (DEPTH_LOG2 + 2)) != '0);
   assign loadIdx       = load_addr[DEPTH_LOG2+1:2];
   assign loadWrite     = load_en && ((load_addr >> (DEPTH_LOG2 + 2)) == '0);
   assign loadHitsFetch = loadWrite && (loadIdx == fetchIdx);

`ifdef IM_BOOT_ROM_EN
   logic [4:0] overridden_q;

   function automatic logic [DATA_WIDTH-1:0] bootWord(input logic [2:0] idx);
      logic [31:0] w;
      case (idx)
         3'd0:    w = 32'h3401000F;
         3'd1:    w = 32'h342100F0;
         3'd2:    w = 32'h34210F00;
         3'd3:    w = 32'h3421F000;
         default: w = 32'h3421AAAA;
      endcase
      return DATA_WIDTH'(w);
   endfunction

   // Remember which boot words have been replaced by a program load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overridden_q <= '0;
      end else if (loadWrite && (loadIdx < BOOT_WORDS)) begin
         overridden_q[loadIdx[2:0]] <= 1'b1;
      end
   end
`endif

   // Program-load write port; the array has no reset and out-of-range loads
   // are simply dropped.
   always_ff @(posedge clk) begin
      if (loadWrite) begin
         mem_q[loadIdx] <= load_data;
      end
   end

   // Read word seen at the RESP-entry edge: a load landing on the same edge
   // and word is forwarded so the fetch returns the freshly written value.
   always_comb begin
      readWord = mem_q[fetchIdx];
      if (loadHitsFetch) begin
         readWord = load_data;
      end
`ifdef IM_BOOT_ROM_EN
      if ((fetchIdx < BOOT_WORDS) && !overridden_q[fetchIdx[2:0]] && !loadHitsFetch) begin
         readWord = bootWord(fetchIdx[2:0]);
      end
`endif
   end

   // Fetch FSM: accept in IDLE, count wait states, then a one-cycle response
   // whose data/error are captured on the edge that enters RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      rspValid_d = 1'b0;
      rspInst_d  = rspInst_q;
      rspErr_d   = rspErr_q;
      req_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = !load_en;
            if (req_valid && !load_en) begin
               addr_d  = req_addr;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if ((state_d == RESP) && (state_q != RESP)) begin
         rspValid_d = 1'b1;
         rspErr_d   = fetchErr;
         rspInst_d  = fetchErr ? '0 : readWord;
      end
   end

   // State and response registers; reset aborts any fetch in flight without
   // producing a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         rspValid_q <= 1'b0;
         rspInst_q  <= '0;
         rspErr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         rspValid_q <= rspValid_d;
         rspInst_q  <= rspInst_d;
         rspErr_q   <= rspErr_d;
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_inst  = rspInst_q;
   assign rsp_err   = rspErr_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_im_sync.sv
// tb_im_sync: bench for im_sync with three instances at WAIT_STATES 1, 0, 3.
// Expected responses are queued when a request is driven and popped when
// rsp_valid pulses.
`timescale 1ns/1ps
module tb_im_sync;

   localparam int NINST = 3;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid [NINST];
   logic [31:0] reqAddr  [NINST];
   logic        loadEn   [NINST];
   logic [31:0] loadAddr [NINST];
   logic [31:0] loadData [NINST];
   logic        reqReady [NINST];
   logic        rspValid [NINST];
   logic [31:0] rspInst  [NINST];
   logic        rspErr   [NINST];
   logic        busy     [NINST];

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t expQ[$];

   for (genvar g = 0; g < NINST; g++) begin : gDut
      im_sync #(
         .ADDR_WIDTH (32),
         .DATA_WIDTH (32),
         .DEPTH_LOG2 (8),
         .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (reqValid[g]),
         .req_ready (reqReady[g]),
         .req_addr  (reqAddr[g]),
         .rsp_valid (rspValid[g]),
         .rsp_inst  (rspInst[g]),
         .rsp_err   (rspErr[g]),
         .load_en   (loadEn[g]),
         .load_addr (loadAddr[g]),
         .load_data (loadData[g]),
         .busy      (busy[g])
      );
   end

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   function automatic int wsOf(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic loadWord(input int k, input logic [31:0] addr, input logic [31:0] data);
      loadEn[k]   = 1'b1;
      loadAddr[k] = addr;
      loadData[k] = data;
      stepCycle();
      loadEn[k]   = 1'b0;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
   endtask

   task automatic issueReq(input int k, input logic [31:0] addr, output bit ok);
      reqValid[k] = 1'b1;
      reqAddr[k]  = addr;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (reqReady[k] === 1'b1) ok = 1'b1;
         stepCycle();
      end
      reqValid[k] = 1'b0;
   endtask

   task automatic waitRsp(input int k, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (rspValid[k] === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NINST; k++) begin
         vectors++;
         if ({reqReady[k], rspValid[k], rspInst[k], rspErr[k], busy[k]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_state inst%0d: got ready=%b valid=%b inst=%h err=%b busy=%b, expected 1 0 00000000 0 0",
                     k, reqReady[k], rspValid[k], rspInst[k], rspErr[k], busy[k]);
         end
      end
      stepCycle();
      rst = 1'b0;
      stepCycle();
   endtask

   task automatic test_basic_fetch();
      exp_t e;
      int   ws = wsOf(0);
      loadWord(0, 32'h20, 32'h12345678);
      e.inst = 32'h12345678;
      e.err  = 1'b0;
      expQ.push_back(e);
      reqValid[0] = 1'b1;
      reqAddr[0]  = 32'h20;
      @(negedge clk);
      vectors++;
      if (reqReady[0] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL basic_ready_T: got %b expected 1", reqReady[0]);
      end
      stepCycle();
      reqValid[0] = 1'b0;
      for (int c = 1; c <= ws + 2; c++) begin
         @(negedge clk);
         vectors++;
         if (rspValid[0] !== 1'(c == ws + 1)) begin
            miscompares++;
            $display("[TB] FAIL basic_latency T+%0d: got rsp_valid=%b expected %b", c, rspValid[0], (c == ws + 1));
         end
         if (c <= ws + 1) begin
            vectors++;
            if (reqReady[0] !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL basic_ready_busy T+%0d: got %b expected 0", c, reqReady[0]);
            end
         end
         if (rspValid[0] === 1'b1 && expQ.size() > 0) begin
            e = expQ.pop_front();
            vectors++;
            if (rspInst[0] !== e.inst || rspErr[0] !== e.err) begin
               miscompares++;
               $display("[TB] FAIL basic_rsp: got inst=%h err=%b expected inst=%h err=%b", rspInst[0], rspErr[0], e.inst, e.err);
            end
         end
      end
      vectors++;
      if (rspInst[0] !== 32'h12345678) begin
         miscompares++;
         $display("[TB] FAIL basic_hold: got %h expected 12345678", rspInst[0]);
      end
      stepCycle();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   acc[$];
      int   rspCount = 0;
      logic prevValid = 1'b0;
      loadWord(1, 32'h0, 32'hA0A0_0001);
      loadWord(1, 32'h4, 32'hB0B0_0002);
      e.err  = 1'b0;
      e.inst = 32'hA0A0_0001;
      expQ.push_back(e);
      e.inst = 32'hB0B0_0002;
      expQ.push_back(e);
      reqValid[1] = 1'b1;
      reqAddr[1]  = 32'h0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (rspValid[1] === 1'b1) begin
            rspCount++;
            vectors++;
            if (prevValid !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL b2b_pulse_width cycle %0d: got rsp_valid high two cycles, expected one", cyc);
            end
            if (expQ.size() > 0) begin
               e = expQ.pop_front();
               vectors++;
               if (rspInst[1] !== e.inst || rspErr[1] !== e.err) begin
                  miscompares++;
                  $display("[TB] FAIL b2b_rsp: got inst=%h err=%b expected inst=%h err=%b", rspInst[1], rspErr[1], e.inst, e.err);
               end
            end
         end
         prevValid = rspValid[1];
         if (reqValid[1] === 1'b1 && reqReady[1] === 1'b1) acc.push_back(cyc);
         stepCycle();
         if (acc.size() == 1) reqAddr[1] = 32'h4;
         if (acc.size() >= 2) reqValid[1] = 1'b0;
      end
      reqValid[1] = 1'b0;
      vectors++;
      if (acc.size() != 2 || rspCount != 2) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: got %0d accepts %0d responses expected 2 and 2", acc.size(), rspCount);
      end else begin
         vectors++;
         if (acc[1] - acc[0] != wsOf(1) + 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles expected %0d", acc[1] - acc[0], wsOf(1) + 2);
         end
      end
   endtask

   task automatic test_errors();
      exp_t        e;
      bit          ok;
      bit          seen;
      logic [31:0] addrs [2];
      addrs[0] = 32'h22;
      addrs[1] = 32'h400;
      for (int i = 0; i < 2; i++) begin
         e.inst = 32'h0;
         e.err  = 1'b1;
         expQ.push_back(e);
         issueReq(0, addrs[i], ok);
         waitRsp(0, seen);
         vectors++;
         if (!ok || !seen) begin
            miscompares++;
            $display("[TB] FAIL err_timeout addr %h: got accepted=%b response=%b expected 1 1", addrs[i], ok, seen);
            expQ.delete();
         end else begin
            e = expQ.pop_front();
            if (rspInst[0] !== e.inst || rspErr[0] !== e.err) begin
               miscompares++;
               $display("[TB] FAIL err_rsp addr %h: got inst=%h err=%b expected inst=%h err=%b", addrs[i], rspInst[0], rspErr[0], e.inst, e.err);
            end
         end
         stepCycle();
      end
   endtask

   task automatic test_load_collision();
      exp_t e;
      bit   seen;
      loadWord(0, 32'h30, 32'h11111111);
      e.inst = 32'h55AA55AA;
      e.err  = 1'b0;
      expQ.push_back(e);
      loadEn[0]   = 1'b1;
      loadAddr[0] = 32'h30;
      loadData[0] = 32'h55AA55AA;
      reqValid[0] = 1'b1;
      reqAddr[0]  = 32'h30;
      @(negedge clk);
      vectors++;
      if (reqReady[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL collide_ready_blocked: got %b expected 0", reqReady[0]);
      end
      stepCycle();
      loadEn[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if (reqReady[0] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL collide_ready_after: got %b expected 1", reqReady[0]);
      end
      stepCycle();
      reqValid[0] = 1'b0;
      waitRsp(0, seen);
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("[TB] FAIL collide_timeout: got no response expected one");
         expQ.delete();
      end else begin
         e = expQ.pop_front();
         if (rspInst[0] !== e.inst || rspErr[0] !== e.err) begin
            miscompares++;
            $display("[TB] FAIL collide_rsp: got inst=%h err=%b expected inst=%h err=%b", rspInst[0], rspErr[0], e.inst, e.err);
         end
      end
      stepCycle();
   endtask

   task automatic test_load_during_wait();
      exp_t e;
      bit   ok;
      bit   seen;
      loadWord(2, 32'h40, 32'hCAFE0001);
      e.inst = 32'hCAFE0002;
      e.err  = 1'b0;
      expQ.push_back(e);
      issueReq(2, 32'h40, ok);
      vectors++;
      if (busy[2] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wait_busy: got %b expected 1", busy[2]);
      end
      repeat (wsOf(2) - 1) stepCycle();
      loadEn[2]   = 1'b1;
      loadAddr[2] = 32'h40;
      loadData[2] = 32'hCAFE0002;
      stepCycle();
      loadEn[2] = 1'b0;
      waitRsp(2, seen);
      vectors++;
      if (!ok || !seen) begin
         miscompares++;
         $display("[TB] FAIL wait_load_timeout: got accepted=%b response=%b expected 1 1", ok, seen);
         expQ.delete();
      end else begin
         e = expQ.pop_front();
         if (rspInst[2] !== e.inst || rspErr[2] !== e.err) begin
            miscompares++;
            $display("[TB] FAIL wait_load_rsp: got inst=%h err=%b expected inst=%h err=%b", rspInst[2], rspErr[2], e.inst, e.err);
         end
      end
      stepCycle();
   endtask

   task automatic test_reset_mid_fetch();
      bit ok;
      bit sawPulse = 1'b0;
      issueReq(2, 32'h44, ok);
      stepCycle();
      vectors++;
      if (!ok || busy[2] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_pre: got accepted=%b busy=%b expected 1 1", ok, busy[2]);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy[2] !== 1'b0 || reqReady[2] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_state: got busy=%b ready=%b expected 0 1", busy[2], reqReady[2]);
      end
      stepCycle();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rspValid[2] === 1'b1) sawPulse = 1'b1;
      end
      vectors++;
      if (sawPulse) begin
         miscompares++;
         $display("[TB] FAIL abort_pulse: got rsp_valid pulse expected none");
      end
      stepCycle();
   endtask

`ifdef IM_BOOT_ROM_EN
   task automatic test_boot_rom();
      exp_t        e;
      bit          ok;
      bit          seen;
      logic [31:0] expv [3];
      expv[0] = 32'h3421AAAA;
      expv[1] = 32'hDEADBEEF;
      expv[2] = 32'h3421AAAA;
      pulseReset();
      for (int s = 0; s < 3; s++) begin
         if (s == 1) loadWord(0, 32'h10, 32'hDEADBEEF);
         if (s == 2) pulseReset();
         e.inst = expv[s];
         e.err  = 1'b0;
         expQ.push_back(e);
         issueReq(0, 32'h10, ok);
         waitRsp(0, seen);
         vectors++;
         if (!ok || !seen) begin
            miscompares++;
            $display("[TB] FAIL boot_timeout step %0d: got accepted=%b response=%b expected 1 1", s, ok, seen);
            expQ.delete();
         end else begin
            e = expQ.pop_front();
            if (rspInst[0] !== e.inst || rspErr[0] !== e.err) begin
               miscompares++;
               $display("[TB] FAIL boot_rsp step %0d: got inst=%h err=%b expected inst=%h err=%b", s, rspInst[0], rspErr[0], e.inst, e.err);
            end
         end
         stepCycle();
      end
   endtask
`endif

   // Drive every scenario in order, then report.
   initial begin
      rst = 1'b1;
      for (int k = 0; k < NINST; k++) begin
         reqValid[k] = 1'b0;
         reqAddr[k]  = '0;
         loadEn[k]   = 1'b0;
         loadAddr[k] = '0;
         loadData[k] = '0;
      end
      test_reset();
      test_basic_fetch();
      test_back_to_back();
      test_errors();
      test_load_collision();
      test_load_during_wait();
      test_reset_mid_fetch();
`ifdef IM_BOOT_ROM_EN
      test_boot_rom();
`endif
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d outstanding expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/im_sync.md
Name: im_sync

Overview:
- Parametrised, clocked instruction memory for the multi-cycle CPU; successor to the fixed combinational program ROM.
- Word-addressed RAM array with a request/response fetch port and configurable wait states, so the fetch stage can model slow memory.
- Also has a program-load write port, plus alignment and range error reporting.
- Sits between the PC/fetch state of the control FSM and the instruction register.

Parameters:
- ADDR_WIDTH, 32, width of byte address on fetch and load ports
- DATA_WIDTH, 32, instruction word width
- DEPTH_LOG2, 8, log2 of number of words (256 words = 1 KiB)
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request
- req_ready  out  1  block can accept a request this cycle
- req_addr  in  ADDR_WIDTH  byte address of fetch (PC)
- rsp_valid  out  1  one-cycle pulse: rsp_inst/rsp_err valid
- rsp_inst  out  DATA_WIDTH  fetched instruction
- rsp_err  out  1  fetch was misaligned or out of range
- load_en  in  1  write one word into array
- load_addr  in  ADDR_WIDTH  byte address of load (bits [1:0] ignored)
- load_data  in  DATA_WIDTH  word to write
- busy  out  1  fetch in progress (state != IDLE)

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_inst=0, rsp_err=0, busy=0, wait counter=0. The array itself has no reset.
- FSM states:
  - IDLE: req_ready = !load_en. On req_valid & req_ready, latch req_addr and load counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement counter each cycle; at counter==1 go to RESP.
  - RESP: drive rsp_valid=1 for exactly one cycle, then return to IDLE. No back-pressure on the response.
- Latency: acceptance edge to rsp_valid high is exactly WAIT_STATES+1 cycles. Throughput is one fetch per WAIT_STATES+2 cycles.
- req_ready=0 in WAIT and RESP. A req_valid held there is not accepted until IDLE.
- Address decode:
  - Word index = latched addr[DEPTH_LOG2+1:2].
  - Misaligned: addr[1:0]!=0.
  - Out of range: any addr bit above DEPTH_LOG2+1 is nonzero.
  - On error: rsp_err=1, rsp_inst=0 (NOP), array not read.
- rsp_inst/rsp_err hold their last value after the rsp_valid pulse until the next RESP.
- Load:
  - load_en writes load_data to word load_addr[DEPTH_LOG2+1:2] at the clock edge, in any state.
  - Out-of-range load addresses are dropped silently.
- Load/fetch collision:
  - In IDLE, load_en blocks request acceptance (req_ready=0).
  - A load during WAIT to the word being fetched is visible in the response; the array is read in the RESP-entry cycle.
- Reset mid-fetch returns to IDLE immediately. No response pulse is issued for the aborted fetch.

Optional Feature:
- Macro IM_BOOT_ROM_EN.
- Defined:
  - Words 0..4 return built-in boot program 0x3401000F, 0x342100F0, 0x34210F00, 0x3421F000, 0x3421AAAA.
  - Each word keeps doing so until loaded. A per-word 5-bit "overridden" register, cleared by rst, is set by a load to that word; once set, array contents are returned instead.
- Undefined: no boot words and no override register; all words come from the array, which is undefined until loaded.

Test Plan:
- WAIT_STATES=1, load 0x12345678 at addr 0x20, request 0x20 at cycle T -> rsp_valid only at T+2, rsp_inst=0x12345678, rsp_err=0, req_ready low at T+1 and T+2.
- WAIT_STATES=0, back-to-back requests 0x0,0x4 held valid -> accepted every 2nd cycle, responses in order, each rsp_valid one cycle wide.
- Request 0x22 (misaligned), then 0x400 with DEPTH_LOG2=8 (out of range) -> rsp_err=1, rsp_inst=0 for both.
- load_en and req_valid both high in IDLE -> load written, req_ready=0, request accepted the following cycle and returns new data.
- Assert rst during WAIT with WAIT_STATES=3 -> busy=0, req_ready=1 next cycle, no rsp_valid pulse ever for that fetch.
- IM_BOOT_ROM_EN defined: fetch 0x10 after reset -> 0x3421AAAA. Load 0xDEADBEEF at 0x10, fetch 0x10 -> 0xDEADBEEF. Reset, fetch 0x10 -> 0x3421AAAA again.
